// File: rtl/data_mem_unit.sv
// Data memory unit: byte-addressable word array with RISC-V load/store sizing,
// valid/ready request and response handshakes, and optional zero-fill after reset.
module data_mem_unit #(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH * 4 > 2 ** ADDR_W) begin : g_bad_params
        $error("data_mem_unit: DEPTH*4 exceeds the ADDR_W byte address space");
    end

    typedef enum logic {StClear, StRun} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] word_addr;
    logic [IDX_W-1:0]  mem_idx;
    logic              accept;
    logic              req_err;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    assign req_ready = !Rst && (state == StRun) && (!rsp_valid || rsp_ready);
    assign init_done = !Rst && (state == StRun);
    assign accept    = req_valid && req_ready;
    assign word_addr = req_addr[ADDR_W-1:2];
    assign mem_idx   = word_addr[IDX_W-1:0];
    assign rd_word   = mem[mem_idx];

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
        if (32'(word_addr) >= DEPTH) begin
            req_err = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        wr_be   = 4'hF;
        wr_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'hF;
                wr_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = rd_word[{req_addr[1:0], 3'b000} +: 8];
        ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            if (state == StClear) begin
                mem[clr_idx] <= '0;
            end else if (accept && req_we && !req_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state     <= CLEAR_ON_RESET ? StClear : StRun;
            clr_idx   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (state == StClear) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == IDX_W'(DEPTH - 1)) begin
                    state <= StRun;
                end
            end
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_err   <= req_err;
                rsp_rdata <= (req_we || req_err) ? 32'h0 : ld_data;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_data_mem_unit;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 11;

    logic              CLK = 1'b0;
    logic              Rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [2:0]        req_funct3 = '0;
    logic              rsp_ready = 1'b1;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int          waited;

    always #5 CLK = ~CLK;

    data_mem_unit #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK),
        .Rst(Rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .init_done(init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response handshake completes at the posedge following this negedge.
    always @(negedge CLK) begin
        if (!Rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got err=%0b data=0x%08h, expected no response",
                         rsp_err, rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(mon_exp[32]));
                check("rsp_rdata", rsp_rdata, mon_exp[31:0]);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input logic err, input logic [31:0] rd,
                         output int nwait);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        nwait      = 0;
        while (1) begin
            @(negedge CLK);
            if (req_ready) break;
            nwait++;
            if (nwait > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", nwait);
                req_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back({err, rd});
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [ADDR_W-1:0] addr, input logic [31:0] rd);
        int w;
        issue(1'b0, f3, addr, 32'h0, 1'b0, rd, w);
    endtask

    task automatic st(input logic [2:0] f3, input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        int w;
        issue(1'b1, f3, addr, wd, 1'b0, 32'h0, w);
    endtask

    task automatic bad(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr);
        int w;
        issue(we, f3, addr, 32'hDEADBEEF, 1'b1, 32'h0, w);
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        @(posedge CLK);
        #1;
        Rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, n, 256);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pulse_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        wait_init("init_latency");
        check("run_req_ready", 32'(req_ready), 1);
        ld(3'b010, 11'h3FC, 32'h00000000);

        // Sizing and extension on one word.
        st(3'b010, 11'h080, 32'h8001F07F);
        ld(3'b000, 11'h080, 32'h0000007F);
        ld(3'b100, 11'h081, 32'h000000F0);
        ld(3'b001, 11'h082, 32'hFFFF8001);
        ld(3'b101, 11'h082, 32'h00008001);
        ld(3'b010, 11'h080, 32'h8001F07F);

        // Partial stores merge into the existing word.
        st(3'b010, 11'h010, 32'h11223344);
        st(3'b000, 11'h013, 32'h000000AA);
        st(3'b001, 11'h010, 32'h0000BEEF);
        ld(3'b010, 11'h010, 32'hAA22BEEF);

        // Rejected requests leave the array alone.
        bad(1'b0, 3'b001, 11'h021);
        bad(1'b1, 3'b010, 11'h022);
        bad(1'b0, 3'b011, 11'h010);
        bad(1'b1, 3'b110, 11'h010);
        bad(1'b0, 3'b111, 11'h010);
        bad(1'b0, 3'b010, 11'h400);
        bad(1'b1, 3'b010, 11'h400);
        bad(1'b1, 3'b100, 11'h010);
        ld(3'b010, 11'h010, 32'hAA22BEEF);
        ld(3'b010, 11'h020, 32'h00000000);
        ld(3'b010, 11'h000, 32'h00000000);

        // Load right after a store to the same word.
        st(3'b010, 11'h040, 32'hCAFEF00D);
        st(3'b000, 11'h042, 32'h00000055);
        ld(3'b101, 11'h042, 32'h0000CA55);
        ld(3'b010, 11'h040, 32'hCA55F00D);

        // Backpressure: response holds, no accept, then release and stream.
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        ld(3'b010, 11'h080, 32'h8001F07F);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 11'h010;
        repeat (3) begin
            @(negedge CLK);
            check("stall_req_ready", 32'(req_ready), 0);
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rdata", rsp_rdata, 32'h8001F07F);
        end
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("release_accept", 32'(req_ready), 1);
        exp_q.push_back({1'b0, 32'hAA22BEEF});
        @(posedge CLK);
        #1;
        issue(1'b0, 3'b100, 11'h080, 32'h0, 1'b0, 32'h0000007F, waited);
        check("b2b_wait_c", 32'(waited), 0);
        issue(1'b0, 3'b000, 11'h081, 32'h0, 1'b0, 32'hFFFFFFF0, waited);
        check("b2b_wait_d", 32'(waited), 0);
        check("b2b_rsp_valid", 32'(rsp_valid), 1);
        @(posedge CLK);
        #1;
        check("rsp_valid_drop", 32'(rsp_valid), 0);

        // Reset with a response pending, then reset again mid-clear.
        st(3'b010, 11'h200, 32'h12345678);
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        ld(3'b010, 11'h200, 32'h12345678);
        Rst = 1'b1;
        #1;
        check("rst_hold_req_ready", 32'(req_ready), 0);
        check("rst_hold_init_done", 32'(init_done), 0);
        @(posedge CLK);
        #1;
        Rst = 1'b0;
        exp_q.delete();
        check("pending_dropped", 32'(rsp_valid), 0);
        rsp_ready = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        check("midclear_init_done", 32'(init_done), 0);
        pulse_reset();
        wait_init("restart_latency");
        ld(3'b010, 11'h200, 32'h00000000);
        ld(3'b010, 11'h080, 32'h00000000);

        repeat (3) @(posedge CLK);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
